// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / flush / forwarding / drain-to-halt control for the
// in-order core. Tracks destination metadata of every in-flight instruction
// from E (entry 0) to W (entry STAGES-1).
// Build option: define PIPE_CTRL_FWD_EN to enable execute-stage operand
// forwarding; without it the core stalls on every in-flight producer.
module pipe_ctrl #(
    parameter int STAGES   = 3,
    parameter int BR_STAGE = 1,
    parameter int REG_SIZE = 5,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         validD,
    input  logic [REG_SIZE-1:0]          rs1D,
    input  logic [REG_SIZE-1:0]          rs2D,
    input  logic                         use1D,
    input  logic                         use2D,
    input  logic [REG_SIZE-1:0]          rdD,
    input  logic                         regWriteD,
    input  logic                         mem2regD,
    input  logic                         finishD,
    input  logic                         redirect,
    output logic                         stallF,
    output logic                         stallD,
    output logic                         flushD,
    output logic [STAGES-1:0]            flushMask,
    output logic [$clog2(STAGES+1)-1:0]  fwd1E,
    output logic [$clog2(STAGES+1)-1:0]  fwd2E,
    output logic [CNT_W-1:0]             retired,
    output logic                         halt
);

    localparam int SEL_W = $clog2(STAGES + 1);
    // Entries younger than the resolving branch: indices 0 .. BR_STAGE-1
    localparam logic [STAGES-1:0] BR_MASK = STAGES'((64'd1 << BR_STAGE) - 64'd1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } stateT;

    stateT state, stateNext;

    // valid is control (reset); the rest is data qualified by valid (not reset)
    logic [STAGES-1:0]   entValid;
    logic [STAGES-1:0]   entRegWrite;
    logic [STAGES-1:0]   entFinish;
    logic [REG_SIZE-1:0] entRd [STAGES];
    logic                mem2regE;
`ifdef PIPE_CTRL_FWD_EN
    logic [REG_SIZE-1:0] rs1E;
    logic [REG_SIZE-1:0] rs2E;
    logic                use1E;
    logic                use2E;
`endif

    logic             loadE;
    logic             loadUse;
    logic             hazard;
    logic             finishSquash;
    logic [SEL_W-1:0] fwd1Sel;
    logic [SEL_W-1:0] fwd2Sel;

    // Non-zero destination that one of the decode-stage used sources reads
    function automatic logic readByD(input logic [REG_SIZE-1:0] rd,
                                     input logic                u1,
                                     input logic [REG_SIZE-1:0] s1,
                                     input logic                u2,
                                     input logic [REG_SIZE-1:0] s2);
        return (rd != '0) && ((u1 && (rd == s1)) || (u2 && (rd == s2)));
    endfunction

    // Entry that will write a non-zero register equal to src
    function automatic logic produces(input logic                v,
                                      input logic                rw,
                                      input logic [REG_SIZE-1:0] rd,
                                      input logic [REG_SIZE-1:0] src);
        return v && rw && (rd != '0) && (rd == src);
    endfunction

    // Hazard detection: a load in E always blocks; without forwarding any producer does
    always_comb begin
        loadUse = entValid[0] && mem2regE && readByD(entRd[0], use1D, rs1D, use2D, rs2D);
        hazard  = loadUse;
`ifndef PIPE_CTRL_FWD_EN
        for (int k = 0; k < STAGES; k++) begin
            if (entValid[k] && entRegWrite[k] &&
                readByD(entRd[k], use1D, rs1D, use2D, rs2D)) begin
                hazard = 1'b1;
            end
        end
`endif
    end

`ifdef PIPE_CTRL_FWD_EN
    // Forward select: scan oldest to youngest so the nearest producer overrides
    always_comb begin
        fwd1Sel = '0;
        fwd2Sel = '0;
        if (entValid[0]) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (use1E && produces(entValid[k], entRegWrite[k], entRd[k], rs1E)) begin
                    fwd1Sel = SEL_W'(k);
                end
                if (use2E && produces(entValid[k], entRegWrite[k], entRd[k], rs2E)) begin
                    fwd2Sel = SEL_W'(k);
                end
            end
        end
    end
`else
    assign fwd1Sel = '0;
    assign fwd2Sel = '0;
`endif

    // A redirect kills a younger finish that has not yet passed the branch
    assign finishSquash = redirect && (|(entValid & entFinish & BR_MASK));

    // Decode instruction enters E only while running and not held or squashed
    assign loadE = validD && !stallD && !flushD && (state == RUN);

    // Next-state logic of the finish drain machine
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (loadE && finishD) stateNext = DRAIN;
            end
            DRAIN: begin
                if (finishSquash)                                   stateNext = RUN;
                else if (entValid[STAGES-1] && entFinish[STAGES-1]) stateNext = HALT;
            end
            HALT:    stateNext = HALT;
            default: stateNext = RUN;
        endcase
    end

    // Stall / flush / forward outputs; redirect beats stall except when halted
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushMask = '0;
        fwd1E     = '0;
        fwd2E     = '0;
        if (reset) begin
            flushD    = redirect;
            flushMask = redirect ? BR_MASK : '0;
            fwd1E     = fwd1Sel;
            fwd2E     = fwd2Sel;
            if (state == HALT) begin
                stallF = 1'b1;
                stallD = 1'b1;
            end else if (!redirect) begin
                stallD = hazard;
                stallF = hazard || (state == DRAIN);
            end
        end
    end

    // State register and registered halt flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= stateNext;
            halt  <= (stateNext == HALT);
        end
    end

    // Valid chain: advances every cycle, entries behind the branch shift in bubbles
    always_ff @(posedge clk) begin
        if (!reset) begin
            entValid <= '0;
        end else begin
            entValid[0] <= loadE;
            for (int k = 1; k < STAGES; k++) begin
                entValid[k] <= (redirect && (k <= BR_STAGE)) ? 1'b0 : entValid[k-1];
            end
        end
    end

    // Metadata chain: free-running, only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        entRd[0]       <= rdD;
        entRegWrite[0] <= regWriteD;
        entFinish[0]   <= finishD;
        mem2regE       <= mem2regD;
`ifdef PIPE_CTRL_FWD_EN
        rs1E           <= rs1D;
        rs2E           <= rs2D;
        use1E          <= use1D;
        use2E          <= use2D;
`endif
        for (int k = 1; k < STAGES; k++) begin
            entRd[k]       <= entRd[k-1];
            entRegWrite[k] <= entRegWrite[k-1];
            entFinish[k]   <= entFinish[k-1];
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired <= '0;
        end else if (entValid[STAGES-1]) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl,
// compared cycle by cycle with an instruction-queue reference model.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
    localparam int S   = 3;
    localparam bit FWD = 1'b1;
`else
    localparam int S   = 5;
    localparam bit FWD = 1'b0;
`endif
    localparam int BR = 1;
    localparam int RS = 5;
    localparam int CW = 4;
    localparam int SW = $clog2(S + 1);

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit       rw;
        bit       m2r;
        bit       fin;
    } instT;

    logic          clk = 1'b0;
    logic          reset;
    logic          validD;
    logic [RS-1:0] rs1D, rs2D, rdD;
    logic          use1D, use2D, regWriteD, mem2regD, finishD, redirect;
    logic          stallF, stallD, flushD, halt;
    logic [S-1:0]  flushMask;
    logic [SW-1:0] fwd1E, fwd2E;
    logic [CW-1:0] retired;

    instT dIn;
    bit   redirIn;
    bit   resetIn;

    assign reset     = resetIn;
    assign redirect  = redirIn;
    assign validD    = dIn.v;
    assign rs1D      = dIn.rs1;
    assign rs2D      = dIn.rs2;
    assign rdD       = dIn.rd;
    assign use1D     = dIn.u1;
    assign use2D     = dIn.u2;
    assign regWriteD = dIn.rw;
    assign mem2regD  = dIn.m2r;
    assign finishD   = dIn.fin;

    pipe_ctrl #(
        .STAGES   (S),
        .BR_STAGE (BR),
        .REG_SIZE (RS),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .validD    (validD),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .use1D     (use1D),
        .use2D     (use2D),
        .rdD       (rdD),
        .regWriteD (regWriteD),
        .mem2regD  (mem2regD),
        .finishD   (finishD),
        .redirect  (redirect),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushD    (flushD),
        .flushMask (flushMask),
        .fwd1E     (fwd1E),
        .fwd2E     (fwd2E),
        .retired   (retired),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of in-flight instructions, pipe[0] = E
    instT pipe[$];
    int   mode;     // 0 running, 1 draining, 2 halted
    int   mRet;
    bit   mHalt;
    bit   eStallF, eStallD, eFlushD;
    int   eMask, eFwd1, eFwd2;

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
        end
    endtask

    function automatic instT bubble();
        instT b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic instT mk(input int rd, input int rs1, input int rs2, input bit u1,
                                input bit u2, input bit rw, input bit m2r, input bit fin);
        instT i;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = u1; i.u2 = u2; i.rw = rw; i.m2r = m2r; i.fin = fin;
        return i;
    endfunction

    function automatic bit readsD(input instT p, input instT d);
        return (p.rd != 0) && ((d.u1 && p.rd == d.rs1) || (d.u2 && p.rd == d.rs2));
    endfunction

    function automatic bit writes(input instT p, input bit [4:0] r);
        return p.v && p.rw && (p.rd != 0) && (p.rd == r);
    endfunction

    task automatic modelReset();
        pipe.delete();
        repeat (S) pipe.push_back(bubble());
        mode = 0; mRet = 0; mHalt = 1'b0;
    endtask

    task automatic computeExp(input instT d, input bit redir, input bit rstn);
        bit hz;
        eStallF = 0; eStallD = 0; eFlushD = 0; eMask = 0; eFwd1 = 0; eFwd2 = 0;
        if (rstn) begin
            hz = pipe[0].v && pipe[0].m2r && readsD(pipe[0], d);
            if (!FWD) begin
                foreach (pipe[i]) if (pipe[i].v && pipe[i].rw && readsD(pipe[i], d)) hz = 1;
            end
            eFlushD = redir;
            eMask   = redir ? (1 << BR) - 1 : 0;
            if (mode == 2) begin
                eStallF = 1; eStallD = 1;
            end else if (!redir) begin
                eStallD = hz;
                eStallF = hz || (mode == 1);
            end
            if (FWD && pipe[0].v) begin
                for (int k = 1; k < S; k++) begin
                    if (eFwd1 == 0 && pipe[0].u1 && writes(pipe[k], pipe[0].rs1)) eFwd1 = k;
                    if (eFwd2 == 0 && pipe[0].u2 && writes(pipe[k], pipe[0].rs2)) eFwd2 = k;
                end
            end
        end
    endtask

    task automatic updateModel(input instT d, input bit redir, input bit rstn);
        bit load, sq;
        int nextMode;
        if (!rstn) begin
            modelReset();
            return;
        end
        load = d.v && !eStallD && !redir && (mode == 0);
        if (pipe[S-1].v) mRet = (mRet + 1) % (1 << CW);
        nextMode = mode;
        if (mode == 0 && load && d.fin) nextMode = 1;
        if (mode == 1) begin
            sq = 0;
            for (int i = 0; i < BR; i++) if (pipe[i].v && pipe[i].fin) sq = 1;
            if (redir && sq)                      nextMode = 0;
            else if (pipe[S-1].v && pipe[S-1].fin) nextMode = 2;
        end
        void'(pipe.pop_back());
        pipe.push_front(load ? d : bubble());
        if (redir) for (int i = 1; i <= BR; i++) pipe[i] = bubble();
        mode  = nextMode;
        mHalt = (mode == 2);
    endtask

    // Apply inputs mid-cycle and check every output against the model
    task automatic drive(input instT d, input bit redir, input bit rstn);
        @(negedge clk);
        dIn = d; redirIn = redir; resetIn = rstn;
        #1;
        computeExp(d, redir, rstn);
        checkEq("stallF",    32'(stallF),    32'(eStallF));
        checkEq("stallD",    32'(stallD),    32'(eStallD));
        checkEq("flushD",    32'(flushD),    32'(eFlushD));
        checkEq("flushMask", 32'(flushMask), 32'(eMask));
        checkEq("fwd1E",     32'(fwd1E),     32'(eFwd1));
        checkEq("fwd2E",     32'(fwd2E),     32'(eFwd2));
        checkEq("retired",   32'(retired),   32'(mRet));
        checkEq("halt",      32'(halt),      32'(mHalt));
    endtask

    task automatic advance();
        @(posedge clk);
        updateModel(dIn, redirIn, resetIn);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(bubble(), 1'b0, 1'b1);
            advance();
        end
    endtask

    // Present d until it is accepted; returns the number of stall cycles seen
    task automatic feed(input instT d, output int stalls);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            drive(d, 1'b0, 1'b1);
            if (!stallD) begin
                advance();
                return;
            end
            stalls++;
            advance();
        end
        checkEq("feed_bound", 32'(stallD), 32'(0));
    endtask

    initial begin
        int  st, cnt;
        bit  seen;
        dIn = bubble(); redirIn = 1'b0; resetIn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);

        // reset state
        drive(bubble(), 1'b0, 1'b0);
        checkEq("rst_retired", 32'(retired), 32'(0));
        checkEq("rst_halt",    32'(halt),    32'(0));
        advance();
        idle(2);

        // back-to-back dependent ALU ops
        feed(mk(5, 0, 0, 0, 0, 1, 0, 0), st);
        checkEq("t1_prod_stall", 32'(st), 32'(0));
        feed(mk(7, 5, 0, 1, 0, 1, 0, 0), st);
        checkEq("t1_dep_stalls", 32'(st), 32'(FWD ? 0 : S));
        drive(bubble(), 1'b0, 1'b1);
        checkEq("t1_fwd1", 32'(fwd1E), 32'(FWD ? 1 : 0));
        advance();
        idle(S + 1);

        // load-use
        feed(mk(6, 0, 0, 0, 0, 1, 1, 0), st);
        feed(mk(8, 6, 0, 1, 0, 1, 0, 0), st);
        checkEq("t2_lu_stalls", 32'(st), 32'(FWD ? 1 : S));
        drive(bubble(), 1'b0, 1'b1);
        checkEq("t2_fwd1", 32'(fwd1E), 32'(FWD ? 2 : 0));
        advance();
        idle(S + 1);

        // x0 is never a dependency
        feed(mk(0, 0, 0, 0, 0, 1, 0, 0), st);
        feed(mk(9, 0, 0, 1, 1, 1, 0, 0), st);
        checkEq("t3_x0_stalls", 32'(st), 32'(0));
        drive(bubble(), 1'b0, 1'b1);
        checkEq("t3_fwd1", 32'(fwd1E), 32'(0));
        checkEq("t3_fwd2", 32'(fwd2E), 32'(0));
        advance();
        idle(S + 1);

        // redirect during a load-use stall
        feed(mk(6, 0, 0, 0, 0, 1, 1, 0), st);
        drive(mk(8, 6, 0, 1, 0, 1, 0, 0), 1'b1, 1'b1);
        checkEq("t4_stallD", 32'(stallD),    32'(0));
        checkEq("t4_stallF", 32'(stallF),    32'(0));
        checkEq("t4_flushD", 32'(flushD),    32'(1));
        checkEq("t4_mask",   32'(flushMask), 32'(1));
        advance();
        idle(S + 1);

        // finish drain after two ALU instructions
        drive(bubble(), 1'b0, 1'b0);
        advance();
        feed(mk(1, 0, 0, 0, 0, 1, 0, 0), st);
        feed(mk(2, 0, 0, 0, 0, 1, 0, 0), st);
        feed(mk(0, 0, 0, 0, 0, 0, 0, 1), st);
        cnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(bubble(), 1'b0, 1'b1);
            if (i == 0) checkEq("t5_drain_stallF", 32'(stallF), 32'(1));
            if (halt) begin
                seen = 1;
                break;
            end
            cnt++;
            advance();
        end
        checkEq("t5_halt",        32'(halt),    32'(1));
        checkEq("t5_latency",     32'(cnt),     32'(S));
        checkEq("t5_retired",     32'(retired), 32'(3));
        checkEq("t5_halt_stallD", 32'(stallD),  32'(1));
        if (seen) advance();

        // finish and redirect together: finish flushed, still running
        drive(bubble(), 1'b0, 1'b0);
        advance();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b1);
        advance();
        drive(bubble(), 1'b0, 1'b1);
        checkEq("t6_run_stallF", 32'(stallF), 32'(0));
        advance();

        // reset in the middle of a drain
        feed(mk(0, 0, 0, 0, 0, 0, 0, 1), st);
        drive(bubble(), 1'b0, 1'b0);
        advance();
        drive(bubble(), 1'b0, 1'b1);
        checkEq("t7_stallF", 32'(stallF), 32'(0));
        checkEq("t7_halt",   32'(halt),   32'(0));
        advance();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            instT d;
            bit   redir, rstn;
            d.v   = ($urandom % 4) != 0;
            d.rd  = 5'($urandom_range(0, 3));
            d.rs1 = 5'($urandom_range(0, 3));
            d.rs2 = 5'($urandom_range(0, 3));
            d.u1  = 1'($urandom % 2);
            d.u2  = 1'($urandom % 2);
            d.rw  = 1'($urandom % 2);
            d.m2r = ($urandom % 3) == 0;
            d.fin = ($urandom % 50) == 0;
            redir = ($urandom % 10) == 0;
            rstn  = !((($urandom % 300) == 0) || (mode == 2 && ($urandom % 6) == 0));
            drive(d, redir, rstn);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time budget exhausted, checks=%0d", nChecks);
        $fatal(1);
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order RISC-V core: it tracks the destination-register metadata of every in-flight instruction from execute to writeback. From that it generates fetch/decode stall, per-stage flush, execute-stage operand-forwarding selects, a retired-instruction counter and a clean drain-then-halt on the finish instruction. It sits beside the stage modules in the core top level, replacing ad-hoc hazard wiring, and scales to any pipeline depth behind decode.

## Interface
- `STAGES`, 3: tracked stages after decode; index 0 = E, `STAGES-1` = W (min 2).
- `BR_STAGE`, 1: stage index where branch redirect resolves (1 = M); 1 ≤ `BR_STAGE` < `STAGES`.
- `REG_SIZE`, 5: register-index width.
- `CNT_W`, 32: retire-counter width.
- `SEL_W`, `$clog2(STAGES+1)`: forward-select width (localparam).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `validD` in 1: decode holds a real instruction.
- `rs1D`, `rs2D` in `REG_SIZE`: source registers in decode.
- `use1D`, `use2D` in 1: source actually read.
- `rdD` in `REG_SIZE`: destination register.
- `regWriteD`, `mem2regD`, `finishD` in 1: decode control bits.
- `redirect` in 1: taken branch/jump resolved at `BR_STAGE`.
- `stallF`, `stallD` out 1: hold PC / hold the D register.
- `flushD` out 1: squash the D register.
- `flushMask` out `STAGES`: bit k squashes stage k's input register.
- `fwd1E`, `fwd2E` out `SEL_W`: 0 = register file, k = take result of stage k.
- `retired` out `CNT_W`: instructions retired at W.
- `halt` out 1: finish retired, core stopped.

## Operation
- Internal shift chain `ent[0..STAGES-1]`, each entry holds {valid, rd, rs1, rs2, use1, use2, regWrite, mem2reg, finish}. It advances every cycle; there is no stall behind E.
- Entry 0 loads the D fields when `validD & ~stallD & ~flushD & state==RUN`; otherwise it loads a bubble (valid=0).
- Producer k (k ≥ 1) matches a source register when: valid, regWrite, rd ≠ 0 and rd equals that source register.
- Forwarding, `fwdN` for N = 1,2: the smallest k in 1..`STAGES-1` whose producer matches `ent[0].rsN` with `useN`; 0 if none.
- Load-use hazard: `ent[0]` valid & mem2reg & rd ≠ 0 & rd matches a used D source register. This asserts `stallF = stallD = 1`.
- Redirect:
  - `flushD = 1`.
  - `flushMask[k] = 1` for k < `BR_STAGE`.
  - `stallF = stallD = 0`: redirect overrides stall.
  - The corresponding entries shift in invalid.
- Finish FSM, states RUN, DRAIN, HALT:
  - RUN→DRAIN when a finish instruction loads into entry 0.
  - DRAIN: `stallF = 1`, D bubbles.
  - DRAIN→RUN if `redirect` squashes the entry holding finish (index < `BR_STAGE`).
  - DRAIN→HALT when `ent[STAGES-1]` valid & finish.
  - HALT: `halt = 1`, `stallF = stallD = 1`, sticky until reset.
- `retired` increments when `ent[STAGES-1].valid`; wraps modulo 2^`CNT_W`.

## Timing
- Reset (`reset == 0` at a `clk` edge):
  - all entries invalid, state RUN;
  - `retired = 0`, `halt = 0`;
  - `stall*`, `flush*`, `fwd*` all 0.
  - Reset mid-DRAIN returns to RUN.
- Stall, flush and forward outputs are combinational from the entries and the current inputs, valid in the same cycle.
- `halt` is registered; it rises one cycle after the finish instruction is in W.
- A load-use stall lasts exactly 1 cycle with forwarding compiled in.
- Redirect and finish in decode in the same cycle: the finish instruction is flushed and the state stays RUN.

## Configuration
- `PIPE_CTRL_FWD_EN` defined:
  - forwarding as above;
  - stall only on load-use.
- Undefined:
  - `fwd1E = fwd2E = 0` constantly;
  - stall whenever any valid `ent[0..STAGES-1]` with regWrite and rd ≠ 0 matches a used D source register (register file has no write-through).

## Test plan
- **Back-to-back dependent add, FWD_EN, STAGES=3.** x5 written, then consumed next → `fwd1E = 1` for one cycle, no stall.
- **Load-use.** lw x6 then add reading x6 → `stallF = stallD = 1` for exactly 1 cycle, then `fwd1E = 2`.
- **rd = x0.** x0 producer followed by consumer of x0 → `fwd = 0`, no stall.
- **Redirect during stall, BR_STAGE=1.** `redirect` in the load-use stall cycle → `stallD = 0`, `flushD = 1`, `flushMask = 3'b001`.
- **Finish drain.** finish after 2 ALU instructions → DRAIN; `halt = 1` one cycle after finish in W; `retired = 3`.
- **No forwarding, STAGES=5.** FWD_EN undefined; dependent add → 5 stall cycles until the producer leaves W.
